// File: rtl/stage_fx_seq.sv
// Fixed-point layer stage: loads a tap/bias matrix, buffers one input vector,
// then runs one MAC per cycle per row and streams out saturated results.
module stage_fx_seq #(
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int MAX_IN  = 8,
  parameter int MAX_OUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(MAX_IN+1)-1:0]    cfg_in_len,
  input  logic [$clog2(MAX_OUT+1)-1:0]   cfg_out_len,
  input  logic                           cfg_relu,
  input  logic [DATA_W-1:0]              tap_in,
  input  logic                           tap_in_vld,
  input  logic                           tap_in_fst,
  output logic                           tap_in_rdy,
  input  logic [DATA_W-1:0]              st_data,
  input  logic                           st_data_vld,
  input  logic                           st_data_fst,
  output logic                           st_data_rdy,
  output logic [DATA_W-1:0]              st_data_out,
  output logic                           st_data_out_vld,
  output logic                           st_data_out_fst,
  input  logic                           st_data_out_rdy,
  output logic                           taps_valid,
  output logic                           busy,
  output logic                           proto_err
);
  localparam int IN_LW  = $clog2(MAX_IN + 1);
  localparam int OUT_LW = $clog2(MAX_OUT + 1);
  localparam int R_IW   = $clog2(MAX_OUT);
  localparam int C_IW   = $clog2(MAX_IN + 1);
  localparam int X_IW   = $clog2(MAX_IN);
  localparam logic [IN_LW-1:0]  MAX_IN_L  = IN_LW'(MAX_IN);
  localparam logic [OUT_LW-1:0] MAX_OUT_L = OUT_LW'(MAX_OUT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, COLLECT, COMPUTE} state_t;

  state_t                   state_q, state_d;
  logic [IN_LW-1:0]         il_q, il_d, col_q, col_d;
  logic [OUT_LW-1:0]        ol_q, ol_d, row_q, row_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_dat_q, out_dat_d;
  logic                     out_vld_q, out_vld_d, out_fst_q, out_fst_d;
  logic                     taps_valid_q, taps_valid_d;
  logic                     proto_err_q, proto_err_d;
  logic                     busy_q, busy_d;

  logic [DATA_W-1:0] tap_mem [MAX_OUT][MAX_IN+1];
  logic [DATA_W-1:0] x_mem   [MAX_IN];
  logic              tap_we, x_we;
  logic [R_IW-1:0]   tap_wr_r;
  logic [C_IW-1:0]   tap_wr_c;
  logic [X_IW-1:0]   x_wr_i;

  logic [IN_LW-1:0]         il_cfg;
  logic [OUT_LW-1:0]        ol_cfg;
  logic                     tap_hs, data_hs, out_free;
  logic signed [DATA_W-1:0] tap_rd, bias_rd, x_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  base, acc_sum, shifted;
  logic [DATA_W-1:0]        result;

  assign il_cfg = (cfg_in_len == '0 || cfg_in_len > MAX_IN_L) ? MAX_IN_L : cfg_in_len;
  assign ol_cfg = (cfg_out_len == '0 || cfg_out_len > MAX_OUT_L) ? MAX_OUT_L : cfg_out_len;

  assign tap_in_rdy  = !reset && (state_q == IDLE || state_q == LOAD);
  assign st_data_rdy = !reset && ((state_q == COLLECT) ||
                       (state_q == IDLE && taps_valid_q && !(tap_in_vld && tap_in_fst)));
  assign tap_hs   = tap_in_vld && tap_in_rdy;
  assign data_hs  = st_data_vld && st_data_rdy;
  assign out_free = !out_vld_q || st_data_out_rdy;

  assign tap_rd  = tap_mem[row_q[R_IW-1:0]][col_q[C_IW-1:0]];
  assign bias_rd = tap_mem[row_q[R_IW-1:0]][il_q[C_IW-1:0]];
  assign x_rd    = x_mem[col_q[X_IW-1:0]];

  // Row accumulation seeds with the bias aligned to product scale (2*FRAC).
  always_comb begin
    prod    = tap_rd * x_rd;
    base    = (col_q == '0) ? (ACC_W'(bias_rd) <<< FRAC) : acc_q;
    acc_sum = base + ACC_W'(prod);
    shifted = acc_sum >>> FRAC;
    if (shifted > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    else                        result = shifted[DATA_W-1:0];
    if (relu_q && result[DATA_W-1]) result = '0;
  end

  always_comb begin
    state_d      = state_q;
    il_d         = il_q;
    ol_d         = ol_q;
    relu_d       = relu_q;
    row_d        = row_q;
    col_d        = col_q;
    acc_d        = acc_q;
    out_dat_d    = out_dat_q;
    out_fst_d    = out_fst_q;
    out_vld_d    = out_vld_q && !st_data_out_rdy;
    taps_valid_d = taps_valid_q;
    proto_err_d  = proto_err_q;
    tap_we       = 1'b0;
    x_we         = 1'b0;
    tap_wr_r     = '0;
    tap_wr_c     = '0;
    x_wr_i       = '0;
    case (state_q)
      IDLE: begin
        if ((tap_hs && !tap_in_fst) || (data_hs && !st_data_fst)) proto_err_d = 1'b1;
        if (tap_hs && tap_in_fst) begin
          state_d      = LOAD;
          il_d         = il_cfg;
          ol_d         = ol_cfg;
          relu_d       = cfg_relu;
          taps_valid_d = 1'b0;
          tap_we       = 1'b1;
          row_d        = '0;
          col_d        = IN_LW'(1);
        end else if (data_hs && st_data_fst) begin
          il_d   = il_cfg;
          ol_d   = ol_cfg;
          relu_d = cfg_relu;
          x_we   = 1'b1;
          row_d  = '0;
          if (il_cfg == IN_LW'(1)) begin
            state_d = COMPUTE;
            col_d   = '0;
          end else begin
            state_d = COLLECT;
            col_d   = IN_LW'(1);
          end
        end
      end
      LOAD: if (tap_in_vld) begin
        tap_we = 1'b1;
        if (tap_in_fst) begin
          proto_err_d = 1'b1;
          row_d       = '0;
          col_d       = IN_LW'(1);
        end else begin
          tap_wr_r = row_q[R_IW-1:0];
          tap_wr_c = col_q[C_IW-1:0];
          if (col_q == il_q) begin
            col_d = '0;
            if (row_q == ol_q - OUT_LW'(1)) begin
              taps_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              row_d = row_q + OUT_LW'(1);
            end
          end else begin
            col_d = col_q + IN_LW'(1);
          end
        end
      end
      COLLECT: if (st_data_vld) begin
        x_we = 1'b1;
        if (st_data_fst) begin
          proto_err_d = 1'b1;
          if (il_q == IN_LW'(1)) begin
            state_d = COMPUTE;
            col_d   = '0;
          end else begin
            col_d = IN_LW'(1);
          end
        end else begin
          x_wr_i = col_q[X_IW-1:0];
          if (col_q == il_q - IN_LW'(1)) begin
            state_d = COMPUTE;
            col_d   = '0;
          end else begin
            col_d = col_q + IN_LW'(1);
          end
        end
      end
      COMPUTE: begin
        // row_q == ol_q means every row is computed; wait for the last result to drain.
        if (row_q == ol_q) begin
          if (out_free) state_d = IDLE;
        end else if (col_q == il_q - IN_LW'(1)) begin
          if (out_free) begin
            out_dat_d = result;
            out_vld_d = 1'b1;
            out_fst_d = (row_q == '0);
            row_d     = row_q + OUT_LW'(1);
            col_d     = '0;
          end
        end else begin
          acc_d = acc_sum;
          col_d = col_q + IN_LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      il_q         <= '0;
      ol_q         <= '0;
      relu_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      acc_q        <= '0;
      out_dat_q    <= '0;
      out_vld_q    <= 1'b0;
      out_fst_q    <= 1'b0;
      taps_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      il_q         <= il_d;
      ol_q         <= ol_d;
      relu_q       <= relu_d;
      row_q        <= row_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      out_dat_q    <= out_dat_d;
      out_vld_q    <= out_vld_d;
      out_fst_q    <= out_fst_d;
      taps_valid_q <= taps_valid_d;
      proto_err_q  <= proto_err_d;
      busy_q       <= busy_d;
    end
  end

  // Storage is left unreset; taps_valid gates any use of its contents.
  always_ff @(posedge clk) begin
    if (tap_we) tap_mem[tap_wr_r][tap_wr_c] <= tap_in;
    if (x_we)   x_mem[x_wr_i] <= st_data;
  end

  assign st_data_out     = out_dat_q;
  assign st_data_out_vld = out_vld_q;
  assign st_data_out_fst = out_fst_q;
  assign taps_valid      = taps_valid_q;
  assign busy            = busy_q;
  assign proto_err       = proto_err_q;
endmodule

// File: tb/tb_stage_fx_seq.sv
// Directed bench for stage_fx_seq: vector table for the arithmetic, plus
// hand sequences for backpressure, start-up, protocol errors and reset.
module tb_stage_fx_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cfg_in_len;
  logic [4:0]  cfg_out_len;
  logic        cfg_relu;
  logic [15:0] tap_in, st_data, st_data_out;
  logic        tap_in_vld, tap_in_fst, tap_in_rdy;
  logic        st_data_vld, st_data_fst, st_data_rdy;
  logic        st_data_out_vld, st_data_out_fst, st_data_out_rdy;
  logic        taps_valid, busy, proto_err;

  always #5 clk = ~clk;

  stage_fx_seq dut (
    .clk(clk), .reset(reset), .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
    .cfg_relu(cfg_relu), .tap_in(tap_in), .tap_in_vld(tap_in_vld), .tap_in_fst(tap_in_fst),
    .tap_in_rdy(tap_in_rdy), .st_data(st_data), .st_data_vld(st_data_vld),
    .st_data_fst(st_data_fst), .st_data_rdy(st_data_rdy), .st_data_out(st_data_out),
    .st_data_out_vld(st_data_out_vld), .st_data_out_fst(st_data_out_fst),
    .st_data_out_rdy(st_data_out_rdy), .taps_valid(taps_valid), .busy(busy),
    .proto_err(proto_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  typedef struct packed {
    logic             relu;
    logic [0:5][15:0] taps;
    logic [0:1][15:0] d;
    logic [0:1][15:0] e;
  } vec_t;

  vec_t        tab [6];
  logic [15:0] o;
  logic        f;
  int          c, t_hs;

  function automatic vec_t mk(input logic r, input logic [0:5][15:0] t,
                              input logic [0:1][15:0] d, input logic [0:1][15:0] e);
    vec_t v;
    v.relu = r; v.taps = t; v.d = d; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_tap(input logic [15:0] w, input logic fst);
    int n = 0;
    @(negedge clk);
    tap_in = w; tap_in_vld = 1'b1; tap_in_fst = fst;
    #1;
    while (!tap_in_rdy && n < 50) begin @(negedge clk); #1; n++; end
    if (!tap_in_rdy) chk("tap_rdy_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic send_dat(input logic [15:0] w, input logic fst, output int t);
    int n = 0;
    @(negedge clk);
    st_data = w; st_data_vld = 1'b1; st_data_fst = fst;
    #1;
    while (!st_data_rdy && n < 50) begin @(negedge clk); #1; n++; end
    if (!st_data_rdy) chk("data_rdy_timeout", 0, 1);
    t = cyc;
    @(posedge clk);
  endtask

  task automatic load_taps(input logic [0:5][15:0] t);
    for (int i = 0; i < 6; i++) send_tap(t[i], i == 0);
    @(negedge clk);
    tap_in_vld = 1'b0; tap_in_fst = 1'b0;
    #1;
  endtask

  task automatic run_data(input logic [15:0] d0, input logic [15:0] d1, output int t);
    send_dat(d0, 1'b1, t);
    send_dat(d1, 1'b0, t);
    @(negedge clk);
    st_data_vld = 1'b0; st_data_fst = 1'b0;
  endtask

  task automatic get_out(output logic [15:0] d, output logic fo, output int cy);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!st_data_out_vld && n < 100);
    chk("out_vld_seen", st_data_out_vld, 1);
    d = st_data_out; fo = st_data_out_fst; cy = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); #1; n++; end
    chk("return_idle", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab[0] = mk(1'b0, {16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0080, 16'h0000},
                {16'h0300, 16'h0100}, {16'h0580, 16'hFD80});
    tab[1] = mk(1'b1, {16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0080, 16'h0000},
                {16'h0300, 16'h0100}, {16'h0580, 16'h0000});
    tab[2] = mk(1'b0, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                {16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF});
    tab[3] = mk(1'b0, {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
                {16'h7FFF, 16'h7FFF}, {16'h8000, 16'h8000});
    tab[4] = mk(1'b0, {16'h0080, 16'h0040, 16'hFF80, 16'h0000, 16'h0100, 16'h0100},
                {16'h0400, 16'hFC00}, {16'h0080, 16'hFD00});
    tab[5] = mk(1'b0, {16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000},
                {16'h0080, 16'h0000}, {16'hFFFF, 16'h0000});

    reset = 1'b1; cfg_in_len = 4'd2; cfg_out_len = 5'd2; cfg_relu = 1'b0;
    tap_in = '0; tap_in_vld = 1'b0; tap_in_fst = 1'b0;
    st_data = '0; st_data_vld = 1'b0; st_data_fst = 1'b0; st_data_out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tap_rdy", tap_in_rdy, 0);
    chk("rst_data_rdy", st_data_rdy, 0);
    chk("rst_out_vld", st_data_out_vld, 0);
    chk("rst_out_fst", st_data_out_fst, 0);
    chk("rst_out_dat", st_data_out, 0);
    chk("rst_taps_valid", taps_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    reset = 1'b0;
    #1;
    chk("idle_tap_rdy", tap_in_rdy, 1);

    // Data with fst before any taps are loaded must be refused.
    @(negedge clk);
    st_data = 16'h0300; st_data_vld = 1'b1; st_data_fst = 1'b1;
    #1;
    chk("early_data_rdy", st_data_rdy, 0);
    @(negedge clk); #1;
    chk("early_data_busy", busy, 0);
    st_data_vld = 1'b0; st_data_fst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cfg_relu = tab[i].relu;
      load_taps(tab[i].taps);
      chk($sformatf("v%0d_taps_valid", i), taps_valid, 1);
      run_data(tab[i].d[0], tab[i].d[1], t_hs);
      get_out(o, f, c);
      chk($sformatf("v%0d_out0", i), o, tab[i].e[0]);
      chk($sformatf("v%0d_fst0", i), f, 1);
      chk($sformatf("v%0d_latency", i), c - t_hs, 3);
      get_out(o, f, c);
      chk($sformatf("v%0d_out1", i), o, tab[i].e[1]);
      chk($sformatf("v%0d_fst1", i), f, 0);
      wait_idle();
    end
    chk("no_proto_err", proto_err, 0);
    cfg_relu = 1'b0;

    // Backpressure on the first result stalls the second row.
    load_taps(tab[0].taps);
    st_data_out_rdy = 1'b0;
    run_data(16'h0300, 16'h0100, t_hs);
    get_out(o, f, c);
    chk("bp_first", o, 16'h0580);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_dat", st_data_out, 16'h0580);
      chk("bp_hold_vld", st_data_out_vld, 1);
      chk("bp_hold_fst", st_data_out_fst, 1);
    end
    st_data_out_rdy = 1'b1;
    @(negedge clk); #1;
    chk("bp_second_vld", st_data_out_vld, 1);
    chk("bp_second_dat", st_data_out, 16'hFD80);
    chk("bp_second_fst", st_data_out_fst, 0);
    wait_idle();

    // Simultaneous tap fst and data fst: the tap load wins.
    @(negedge clk);
    tap_in = tab[0].taps[0]; tap_in_vld = 1'b1; tap_in_fst = 1'b1;
    st_data = 16'h0300; st_data_vld = 1'b1; st_data_fst = 1'b1;
    #1;
    chk("sim_data_rdy", st_data_rdy, 0);
    chk("sim_tap_rdy", tap_in_rdy, 1);
    @(negedge clk);
    tap_in_vld = 1'b0; tap_in_fst = 1'b0; st_data_vld = 1'b0; st_data_fst = 1'b0;
    #1;
    chk("sim_busy", busy, 1);
    chk("sim_taps_valid", taps_valid, 0);
    for (int i = 1; i < 6; i++) send_tap(tab[0].taps[i], 1'b0);
    @(negedge clk);
    tap_in_vld = 1'b0;
    #1;
    chk("sim_loaded", taps_valid, 1);
    run_data(16'h0300, 16'h0100, t_hs);
    get_out(o, f, c);
    chk("sim_out0", o, 16'h0580);
    get_out(o, f, c);
    chk("sim_out1", o, 16'hFD80);
    wait_idle();
    chk("sim_no_proto_err", proto_err, 0);

    // Restart of the tap load at word 3.
    send_tap(16'h1111, 1'b1);
    send_tap(16'h2222, 1'b0);
    send_tap(16'h3333, 1'b0);
    load_taps(tab[0].taps);
    chk("pe_flag", proto_err, 1);
    chk("pe_taps_valid", taps_valid, 1);
    run_data(16'h0300, 16'h0100, t_hs);
    get_out(o, f, c);
    chk("pe_out0", o, 16'h0580);
    get_out(o, f, c);
    chk("pe_out1", o, 16'hFD80);
    wait_idle();

    // Reset while a result is held in COMPUTE.
    st_data_out_rdy = 1'b0;
    run_data(16'h0300, 16'h0100, t_hs);
    get_out(o, f, c);
    chk("mr_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mr_vld", st_data_out_vld, 0);
    chk("mr_taps_valid", taps_valid, 0);
    chk("mr_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0; st_data_out_rdy = 1'b1;
    st_data = 16'h0300; st_data_vld = 1'b1; st_data_fst = 1'b1;
    #1;
    chk("mr_data_rdy", st_data_rdy, 0);
    chk("mr_proto_err", proto_err, 0);
    @(negedge clk);
    st_data_vld = 1'b0; st_data_fst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
